// File: rtl/spi_cmd_pkg.sv
// ----------------------------------------------------------------------------
// spi_cmd_pkg : opcodes, FSM states and constants shared by spi_cmd.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_cmd_pkg;

  typedef enum logic [3:0] {
    OP_READ_AT    = 4'h1,
    OP_WRITE_AT   = 4'h2,
    OP_READ_NEXT  = 4'h3,
    OP_WRITE_NEXT = 4'h4
  } op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    BUS     = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  localparam logic [7:0] SPI_TX_NO_DATA = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/spi_cmd_sync2.sv
// ----------------------------------------------------------------------------
// sync2 : two-flop synchroniser with asynchronous active-low reset.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/spi_cmd.sv
// ----------------------------------------------------------------------------
// spi_cmd : parses SPI bytes into memory-bus read/write commands.
// Optional feature macro: SPI_CMD_ADDR_INC_EN (auto-increment, *_NEXT opcodes).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_cmd
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  spi_cs_n,
  input  logic                  spi_valid,
  input  logic [7:0]            spi_rx,
  output logic [7:0]            spi_tx,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic                  bus_we,
  output logic                  bus_req,
  input  logic                  bus_done,
  input  logic [DATA_WIDTH-1:0] bus_rd_data
);

  logic cs_s;
  logic valid_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .d     (spi_cs_n),
    .q     (cs_s)
  );

  sync2 #(.RESET_VAL(1'b0)) u_sync_valid (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .d     (spi_valid),
    .q     (valid_s)
  );

  state_t                  state_q, state_d;
  logic                    cs_prev_q, valid_prev_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   rd_hold_q, rd_hold_d;
  logic                    we_q, we_d;
  logic                    req_q, req_d;
  logic                    rd_ok_q, rd_ok_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    abort_q, abort_d;
  logic [7:0]              tx_q, tx_d;

  logic byte_ev;
  logic desel;
  logic byte_acc;

  assign byte_ev  = valid_s & ~valid_prev_q;
  assign desel    = cs_s & ~cs_prev_q;
  // A deselect edge in the same cycle drops the byte.
  assign byte_acc = byte_ev & ~desel;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_hold_d = rd_hold_q;
    we_d      = we_q;
    req_d     = req_q;
    rd_ok_d   = rd_ok_q;
    rd_pend_d = rd_pend_q;
    abort_d   = abort_q;
    tx_d      = tx_q;

    // The byte after a read issue is the turnaround; stage the read result.
    if (byte_acc && !abort_q) begin
      tx_d      = rd_pend_q ? (rd_ok_q ? 8'(rd_hold_q) : SPI_TX_NO_DATA) : 8'h00;
      rd_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (byte_acc) begin
          case (spi_rx[7:4])
            OP_READ_AT: begin
              we_d    = 1'b0;
              state_d = ADDR_HI;
            end
            OP_WRITE_AT: begin
              we_d    = 1'b1;
              state_d = ADDR_HI;
            end
`ifdef SPI_CMD_ADDR_INC_EN
            OP_READ_NEXT: begin
              we_d      = 1'b0;
              rd_pend_d = 1'b1;
              rd_ok_d   = 1'b0;
              state_d   = BUS;
            end
            OP_WRITE_NEXT: begin
              we_d    = 1'b1;
              state_d = DATA;
            end
`endif
            default: state_d = DRAIN;
          endcase
        end
      end
      ADDR_HI: begin
        if (byte_acc) begin
          addr_d  = (ADDR_WIDTH'(spi_rx) << 8) | (addr_q & ADDR_WIDTH'(8'hFF));
          state_d = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (byte_acc) begin
          addr_d = (addr_q & ~ADDR_WIDTH'(8'hFF)) | ADDR_WIDTH'(spi_rx);
          if (we_q) begin
            state_d = DATA;
          end else begin
            rd_pend_d = 1'b1;
            rd_ok_d   = 1'b0;
            state_d   = BUS;
          end
        end
      end
      DATA: begin
        if (byte_acc) begin
          wr_data_d = DATA_WIDTH'(spi_rx);
          state_d   = BUS;
        end
      end
      BUS: begin
        if (desel) begin
          abort_d   = 1'b1;
          rd_pend_d = 1'b0;
        end
        if (!req_q) begin
          req_d = 1'b1;
        end else if (bus_done) begin
          req_d = 1'b0;
          if (!we_q) begin
            rd_hold_d = bus_rd_data;
            rd_ok_d   = 1'b1;
          end
`ifdef SPI_CMD_ADDR_INC_EN
          addr_d = addr_q + ADDR_WIDTH'(1);
`endif
          abort_d = 1'b0;
          state_d = (abort_q || desel) ? IDLE : DRAIN;
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    // The bus cycle in flight is never cut short; elsewhere deselect resets parsing.
    if (desel && state_q != BUS) begin
      state_d   = IDLE;
      rd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cs_prev_q    <= 1'b1;
      valid_prev_q <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      rd_hold_q    <= '0;
      we_q         <= 1'b0;
      req_q        <= 1'b0;
      rd_ok_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      abort_q      <= 1'b0;
      tx_q         <= 8'h00;
    end else begin
      state_q      <= state_d;
      cs_prev_q    <= cs_s;
      valid_prev_q <= valid_s;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      rd_hold_q    <= rd_hold_d;
      we_q         <= we_d;
      req_q        <= req_d;
      rd_ok_q      <= rd_ok_d;
      rd_pend_q    <= rd_pend_d;
      abort_q      <= abort_d;
      tx_q         <= tx_d;
    end
  end

  assign spi_tx      = tx_q;
  assign bus_addr    = addr_q;
  assign bus_wr_data = wr_data_q;
  assign bus_we      = we_q;
  assign bus_req     = req_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd.sv
// ----------------------------------------------------------------------------
// tb_spi_cmd : directed self-checking bench for spi_cmd.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_cmd;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        spi_cs_n;
  logic        spi_valid;
  logic [7:0]  spi_rx;
  logic [7:0]  spi_tx;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_we;
  logic        bus_req;
  logic        bus_done;
  logic [7:0]  bus_rd_data;

  int checks = 0;
  int errors = 0;

  // Bus model / monitor state
  int          bus_lat   = 4;
  logic        hold_done = 1'b0;
  logic [7:0]  rd_val    = 8'h00;
  int          req_count = 0;
  int          stab_err  = 0;
  logic [15:0] last_addr = 16'h0;
  logic [7:0]  last_data = 8'h0;
  logic        last_we   = 1'b0;

  spi_cmd #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .spi_cs_n    (spi_cs_n),
    .spi_valid   (spi_valid),
    .spi_rx      (spi_rx),
    .spi_tx      (spi_tx),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_we      (bus_we),
    .bus_req     (bus_req),
    .bus_done    (bus_done),
    .bus_rd_data (bus_rd_data)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    logic prev_req;
    int   lat_cnt;
    prev_req    = 1'b0;
    lat_cnt     = 0;
    bus_done    = 1'b0;
    bus_rd_data = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      bus_done = 1'b0;
      if (bus_req && !prev_req) begin
        req_count++;
        last_addr = bus_addr;
        last_data = bus_wr_data;
        last_we   = bus_we;
      end else if (bus_req && prev_req) begin
        if (bus_addr !== last_addr || bus_wr_data !== last_data || bus_we !== last_we)
          stab_err++;
      end
      prev_req = bus_req;
      if (bus_req && !hold_done) begin
        if (lat_cnt >= bus_lat) begin
          bus_done    = 1'b1;
          bus_rd_data = rd_val;
          lat_cnt     = 0;
        end else begin
          lat_cnt++;
        end
      end else if (!bus_req) begin
        lat_cnt = 0;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_rx    = b;
    spi_valid = 1'b1;
    wait_clk(8);
    spi_valid = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_select();
    spi_cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_deselect();
    spi_cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_valid = 1'b0;
    spi_rx    = 8'h00;
    wait_clk(4);
    checks++; if (spi_tx !== 8'h00) begin errors++; $display("FAIL reset_tx got %h want 00", spi_tx); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus_we); end
    checks++; if (bus_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", bus_addr); end
    checks++; if (bus_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", bus_wr_data); end
    reset_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_write_at();
    int base;
    base = req_count;
    cs_select();
    send_byte(8'h20); send_byte(8'h80); send_byte(8'h00); send_byte(8'h41);
    wait_clk(10);
    cs_deselect();
    checks++; if (req_count !== base + 1) begin errors++; $display("FAIL wr_reqs got %0d want %0d", req_count - base, 1); end
    checks++; if (last_addr !== 16'h8000) begin errors++; $display("FAIL wr_addr got %h want 8000", last_addr); end
    checks++; if (last_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", last_we); end
    checks++; if (last_data !== 8'h41) begin errors++; $display("FAIL wr_data got %h want 41", last_data); end
    checks++; if (spi_tx !== 8'h00) begin errors++; $display("FAIL wr_tx got %h want 00", spi_tx); end
  endtask

  task automatic test_read_at();
    int base;
    base    = req_count;
    bus_lat = 4;
    rd_val  = 8'h5A;
    cs_select();
    send_byte(8'h10); send_byte(8'hE8); send_byte(8'h10);
    send_byte(8'h00);
    checks++; if (spi_tx !== 8'h5A) begin errors++; $display("FAIL rd_tx got %h want 5a", spi_tx); end
    send_byte(8'h00);
    checks++; if (spi_tx !== 8'h00) begin errors++; $display("FAIL rd_tx_after got %h want 00", spi_tx); end
    cs_deselect();
    checks++; if (req_count !== base + 1) begin errors++; $display("FAIL rd_reqs got %0d want %0d", req_count - base, 1); end
    checks++; if (last_addr !== 16'hE810) begin errors++; $display("FAIL rd_addr got %h want e810", last_addr); end
    checks++; if (last_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b want 0", last_we); end
  endtask

  task automatic test_read_late();
    logic dropped;
    hold_done = 1'b1;
    rd_val    = 8'h77;
    cs_select();
    send_byte(8'h10); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h00);
    checks++; if (spi_tx !== 8'hFF) begin errors++; $display("FAIL late_tx got %h want ff", spi_tx); end
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL late_req_held got %b want 1", bus_req); end
    hold_done = 1'b0;
    dropped   = 1'b0;
    for (int i = 0; i < 50 && !dropped; i++) begin
      wait_clk(1);
      if (!bus_req) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL late_req_drop got %b want 1", dropped); end
    cs_deselect();
  endtask

  task automatic test_abort();
    int base;
    base = req_count;
    cs_select();
    send_byte(8'h20); send_byte(8'h12);
    cs_deselect();
    wait_clk(10);
    checks++; if (req_count !== base) begin errors++; $display("FAIL abort_reqs got %0d want 0", req_count - base); end
    rd_val = 8'hC3;
    cs_select();
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    checks++; if (spi_tx !== 8'hC3) begin errors++; $display("FAIL abort_rd_tx got %h want c3", spi_tx); end
    cs_deselect();
    checks++; if (req_count !== base + 1) begin errors++; $display("FAIL abort_rd_reqs got %0d want 1", req_count - base); end
    checks++; if (last_addr !== 16'h0000) begin errors++; $display("FAIL abort_rd_addr got %h want 0000", last_addr); end
  endtask

  task automatic test_bad_op();
    int base;
    base = req_count;
    cs_select();
    send_byte(8'hF0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h11 * (i + 1));
      checks++; if (spi_tx !== 8'h00) begin errors++; $display("FAIL badop_tx%0d got %h want 00", i, spi_tx); end
    end
    cs_deselect();
    checks++; if (req_count !== base) begin errors++; $display("FAIL badop_reqs got %0d want 0", req_count - base); end
  endtask

  task automatic test_deselect_in_bus();
    int   base;
    logic dropped;
    base      = req_count;
    hold_done = 1'b1;
    cs_select();
    send_byte(8'h20); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h66);
    cs_deselect();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL desel_bus_req got %b want 1", bus_req); end
    hold_done = 1'b0;
    dropped   = 1'b0;
    for (int i = 0; i < 50 && !dropped; i++) begin
      wait_clk(1);
      if (!bus_req) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL desel_bus_drop got %b want 1", dropped); end
    cs_select();
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wait_clk(10);
    cs_deselect();
    checks++; if (req_count !== base + 2) begin errors++; $display("FAIL desel_next_reqs got %0d want 2", req_count - base); end
    checks++; if (last_addr !== 16'h0102) begin errors++; $display("FAIL desel_next_addr got %h want 0102", last_addr); end
    checks++; if (last_data !== 8'h03) begin errors++; $display("FAIL desel_next_data got %h want 03", last_data); end
  endtask

  task automatic test_next_ops();
    int base;
    base = req_count;
`ifdef SPI_CMD_ADDR_INC_EN
    cs_select();
    send_byte(8'h20); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
    wait_clk(10);
    cs_deselect();
    checks++; if (last_addr !== 16'hFFFF) begin errors++; $display("FAIL inc_first_addr got %h want ffff", last_addr); end
    cs_select();
    send_byte(8'h40); send_byte(8'h02);
    wait_clk(10);
    cs_deselect();
    checks++; if (req_count !== base + 2) begin errors++; $display("FAIL inc_reqs got %0d want 2", req_count - base); end
    checks++; if (last_addr !== 16'h0000) begin errors++; $display("FAIL inc_wrap_addr got %h want 0000", last_addr); end
    checks++; if (last_data !== 8'h02) begin errors++; $display("FAIL inc_data got %h want 02", last_data); end
`else
    cs_select();
    send_byte(8'h40); send_byte(8'h02);
    wait_clk(10);
    cs_deselect();
    cs_select();
    send_byte(8'h30); send_byte(8'h00);
    wait_clk(10);
    cs_deselect();
    checks++; if (req_count !== base) begin errors++; $display("FAIL next_unknown_reqs got %0d want 0", req_count - base); end
    checks++; if (spi_tx !== 8'h00) begin errors++; $display("FAIL next_unknown_tx got %h want 00", spi_tx); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_at();
    test_read_at();
    test_read_late();
    test_abort();
    test_bad_op();
    test_deselect_in_bus();
    test_next_ops();
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bus_stable got %0d changes want 0", stab_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
